// File: rtl/encdec_gold_scoreboard_if.sv
// APB signal bundle observed by the EncDec golden scoreboard.
// The master modport drives the bus; the slave modport only observes it.
interface encdec_gold_scoreboard_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA);
endinterface

// File: rtl/encdec_gold_scoreboard.sv
// Golden-model scoreboard for the EncDec block.
// APB writes are snooped into shadow registers. Every operation start pushes
// the expected {data, nof} pair into a small FIFO. Every rising edge of the
// DUT's operation_done is captured, paired with the FIFO head and compared.
module encdec_gold_scoreboard #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    encdec_gold_scoreboard_if.slave      apb,
    input  logic                         operation_done,
    input  logic [DATA_WIDTH-1:0]        data_out,
    input  logic [1:0]                   num_of_errors,
    input  logic                         sb_clear,
    output logic                         mismatch,
    output logic [CNT_WIDTH-1:0]         check_cnt,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_CMP} state_t;

    // Width mask selected by CODEWORD_WIDTH[1:0]: 8 bits, 16 bits, or full data width.
    function automatic logic [DATA_WIDTH-1:0] width_mask(input logic [1:0] cw);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            case (cw)
                2'b00:   m[i] = (i < 8);
                2'b01:   m[i] = (i < 16);
                default: m[i] = 1'b1;
            endcase
        end
        return m;
    endfunction

    // Expected error count: 0 for encode, otherwise derived from masked noise parity.
    function automatic logic [1:0] expected_nof(input logic [1:0] mode,
                                                input logic [DATA_WIDTH-1:0] n);
        logic par;
        logic any;
        par = ^n;
        any = |n;
        if (mode == 2'b00) begin
            return 2'b00;
        end
        return {~par & any, par & any};
    endfunction

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Shadow registers
    logic [AMBA_WORD-1:0]  r_ctrl;
    logic [AMBA_WORD-1:0]  r_data_in;
    logic [AMBA_WORD-1:0]  r_cw;
    logic [AMBA_WORD-1:0]  r_noise;

    // Expected-entry FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
    logic [1:0]            r_fifo_nof  [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    // Compare path
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_done_d;
    logic [DATA_WIDTH-1:0] r_capt_data;
    logic [1:0]            r_capt_nof;
    logic [DATA_WIDTH-1:0] r_exp_data;
    logic [1:0]            r_exp_nof;

    // Status
    logic                  r_mismatch;
    logic [CNT_WIDTH-1:0]  r_check_cnt;
    logic [CNT_WIDTH-1:0]  r_mismatch_cnt;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_apb_wr;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [1:0]            w_push_nof;
    logic                  w_full;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_udf_set;
    logic                  w_compare;
    logic                  w_miscompare;
    logic                  w_unused_bits;

    assign w_apb_wr    = apb.PSEL & apb.PENABLE & apb.PWRITE;
    // CTRL[1:0] = 11 is a plain register update, not an operation start.
    assign w_start     = w_apb_wr & (apb.PADDR[3:2] == 2'b00) & (apb.PWDATA[1:0] != 2'b11);
    // Entry is built from the shadow values as they stood before this edge.
    assign w_mask      = width_mask(r_cw[1:0]);
    assign w_push_data = r_data_in[DATA_WIDTH-1:0] & w_mask;
    assign w_push_nof  = expected_nof(apb.PWDATA[1:0], r_noise[DATA_WIDTH-1:0] & w_mask);
    // A same-edge pop frees a slot, so a full FIFO still accepts the push.
    assign w_full      = (r_level == LVL_FULL);
    assign w_push      = w_start & (~w_full | w_pop);
    assign w_ovf_set   = w_start & w_full & ~w_pop;
    assign w_miscompare = (r_capt_data != r_exp_data) | (r_capt_nof != r_exp_nof);

    // Only CTRL is kept for completeness; its contents never feed the checker.
    assign w_unused_bits = ^{apb.PADDR, r_ctrl, r_cw, r_data_in, r_noise};

    // Shadow register snoop of APB writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_data_in <= '0;
            r_cw      <= '0;
            r_noise   <= '0;
        end else if (w_apb_wr) begin
            case (apb.PADDR[3:2])
                2'b00:   r_ctrl    <= apb.PWDATA;
                2'b01:   r_data_in <= apb.PWDATA;
                2'b10:   r_cw      <= apb.PWDATA;
                default: r_noise   <= apb.PWDATA;
            endcase
        end
    end

    // FIFO storage write (contents need no reset; pointers qualify them)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_nof[r_wr_ptr]  <= w_push_nof;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Compare FSM state register and done-edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_done_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_d <= operation_done;
        end
    end

    // Compare FSM next state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pop       = 1'b0;
        w_udf_set   = 1'b0;
        w_compare   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (operation_done && !r_done_d) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_CMP;
                end else begin
                    w_udf_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CMP: begin
                w_compare   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture DUT result on done edge and FIFO head on pop
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_capt_data <= data_out;
            r_capt_nof  <= num_of_errors;
        end
        if (w_pop) begin
            r_exp_data <= r_fifo_data[r_rd_ptr];
            r_exp_nof  <= r_fifo_nof[r_rd_ptr];
        end
    end

    // Mismatch pulse, saturating counters and sticky flags; clear beats same-edge updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch     <= 1'b0;
            r_check_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_mismatch <= w_compare & w_miscompare;
            if (sb_clear) begin
                r_check_cnt    <= '0;
                r_mismatch_cnt <= '0;
                r_overflow     <= 1'b0;
                r_underflow    <= 1'b0;
            end else begin
                if (w_compare) begin
                    r_check_cnt <= sat_inc(r_check_cnt);
                    if (w_miscompare) r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
                end
                if (w_ovf_set) r_overflow  <= 1'b1;
                if (w_udf_set) r_underflow <= 1'b1;
            end
        end
    end

    assign mismatch     = r_mismatch;
    assign check_cnt    = r_check_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_encdec_gold_scoreboard.sv
// Bench for encdec_gold_scoreboard: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a queue-based behavioural model.
module tb_encdec_gold_scoreboard;

    localparam int AW    = 32;
    localparam int AAW   = 20;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    encdec_gold_scoreboard_if #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(AAW)) apb ();

    logic          operation_done = 1'b0;
    logic [DW-1:0] data_out       = '0;
    logic [1:0]    num_of_errors  = '0;
    logic          sb_clear       = 1'b0;
    logic          mismatch;
    logic [CW-1:0] check_cnt;
    logic [CW-1:0] mismatch_cnt;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          underflow;

    encdec_gold_scoreboard #(
        .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(AAW), .DATA_WIDTH(DW),
        .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .apb(apb),
        .operation_done(operation_done), .data_out(data_out),
        .num_of_errors(num_of_errors), .sb_clear(sb_clear),
        .mismatch(mismatch), .check_cnt(check_cnt), .mismatch_cnt(mismatch_cnt),
        .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    n;
    } entry_t;

    entry_t        q[$];
    logic [AW-1:0] m_data_in = '0, m_cw = '0, m_noise = '0;
    bit            m_prev_done = 0;
    int            m_age = 0;      // edges since an accepted done edge: 0 none, 1 pop due, 2 verdict due
    entry_t        m_head = '0;
    logic [DW-1:0] m_cd = '0;
    logic [1:0]    m_cn = '0;
    int            m_check = 0, m_mcnt = 0;
    bit            m_ovf = 0, m_udf = 0, m_mis = 0;

    always @(posedge clk) begin : model
        entry_t        e;
        logic [DW-1:0] mask;
        logic [DW-1:0] nn;
        bit            inc_chk, inc_mis, set_ovf, set_udf, done_edge;
        if (rst) begin
            q.delete();
            m_data_in = '0; m_cw = '0; m_noise = '0;
            m_prev_done = 0; m_age = 0;
            m_check = 0; m_mcnt = 0; m_ovf = 0; m_udf = 0; m_mis = 0;
        end else begin
            inc_chk = 0; inc_mis = 0; set_ovf = 0; set_udf = 0;
            done_edge = operation_done && !m_prev_done;
            m_mis = 0;
            if (m_age == 2) begin
                inc_chk = 1;
                inc_mis = (m_cd != m_head.d) || (m_cn != m_head.n);
                m_mis   = inc_mis;
                m_age   = 0;
            end else if (m_age == 1) begin
                if (q.size() > 0) begin
                    m_head = q.pop_front();
                    m_age  = 2;
                end else begin
                    set_udf = 1;
                    m_age   = 0;
                end
            end else if (done_edge) begin
                m_cd  = data_out;
                m_cn  = num_of_errors;
                m_age = 1;
            end
            if (apb.PSEL && apb.PENABLE && apb.PWRITE) begin
                case (apb.PADDR[3:2])
                    2'b00: if (apb.PWDATA[1:0] != 2'b11) begin
                        case (m_cw[1:0])
                            2'b00:   mask = 32'h0000_00FF;
                            2'b01:   mask = 32'h0000_FFFF;
                            default: mask = 32'hFFFF_FFFF;
                        endcase
                        nn  = m_noise & mask;
                        e.d = m_data_in & mask;
                        if (apb.PWDATA[1:0] == 2'b00 || nn == 0) e.n = 2'b00;
                        else if ($countones(nn) % 2 == 1)        e.n = 2'b01;
                        else                                     e.n = 2'b10;
                        if (q.size() < DEPTH) q.push_back(e);
                        else                  set_ovf = 1;
                    end
                    2'b01:   m_data_in = apb.PWDATA;
                    2'b10:   m_cw      = apb.PWDATA;
                    default: m_noise   = apb.PWDATA;
                endcase
            end
            if (sb_clear) begin
                m_check = 0; m_mcnt = 0; m_ovf = 0; m_udf = 0;
            end else begin
                if (inc_chk && m_check < CMAX) m_check++;
                if (inc_mis && m_mcnt < CMAX)  m_mcnt++;
                if (set_ovf) m_ovf = 1;
                if (set_udf) m_udf = 1;
            end
            m_prev_done = operation_done;
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mismatch",     64'(mismatch),     64'(m_mis));
            check("check_cnt",    64'(check_cnt),    64'(m_check));
            check("mismatch_cnt", 64'(mismatch_cnt), 64'(m_mcnt));
            check("fifo_level",   64'(fifo_level),   64'(q.size()));
            check("overflow",     64'(overflow),     64'(m_ovf));
            check("underflow",    64'(underflow),    64'(m_udf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb_xfer(input logic [AAW-1:0] a, input logic [AW-1:0] d, input logic wr);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = d;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic done_pulse(input logic [DW-1:0] d, input logic [1:0] n, input int len);
        @(posedge clk); #1;
        operation_done = 1'b1; data_out = d; num_of_errors = n;
        repeat (len) @(posedge clk);
        #1 operation_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        @(posedge clk); #1;
        cmp_en = 1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_chk",   64'(check_cnt),  64'd0);
        check("rst_flags", 64'({mismatch, overflow, underflow}), 64'd0);

        // 1: encode, matching result
        apb_xfer(20'h4, 32'hA5, 1'b1);
        apb_xfer(20'h8, 32'h0,  1'b1);
        apb_xfer(20'h0, 32'h0,  1'b1);
        @(negedge clk);
        check("t1_level", 64'(fifo_level), 64'd1);
        done_pulse(32'hA5, 2'b00, 1);
        idle(4);
        @(negedge clk);
        check("t1_chk",   64'(check_cnt),    64'd1);
        check("t1_mcnt",  64'(mismatch_cnt), 64'd0);
        check("t1_model", 64'(m_check),      64'd1);

        // 2: decode, noise 0x3 in 16-bit width -> expected nof 10, DUT says 01
        apb_xfer(20'h8, 32'h1, 1'b1);
        apb_xfer(20'hC, 32'h3, 1'b1);
        apb_xfer(20'h0, 32'h1, 1'b1);
        done_pulse(32'hA5, 2'b01, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mismatch) pulses++;
        end
        check("t2_pulses",   64'(pulses),       64'd1);
        check("t2_mcnt",     64'(mismatch_cnt), 64'd1);
        check("t2_chk",      64'(check_cnt),    64'd2);
        check("t2_model_nof", 64'(m_head.n),    64'h2);

        // 3: five starts into a 4-deep FIFO, then four matching dones
        @(posedge clk); #1 sb_clear = 1'b1;
        @(posedge clk); #1 sb_clear = 1'b0;
        for (int i = 0; i < 5; i++) apb_xfer(20'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("t3_level_full", 64'(fifo_level), 64'd4);
        check("t3_overflow",   64'(overflow),   64'd1);
        for (int i = 0; i < 4; i++) begin
            done_pulse(32'hA5, 2'b00, 1);
            idle(3);
        end
        @(negedge clk);
        check("t3_chk",   64'(check_cnt),    64'd4);
        check("t3_level", 64'(fifo_level),   64'd0);
        check("t3_mcnt",  64'(mismatch_cnt), 64'd0);

        // 4: done with an empty FIFO, then a normal operation still works
        done_pulse(32'h0, 2'b00, 1);
        idle(3);
        @(negedge clk);
        check("t4_underflow", 64'(underflow), 64'd1);
        check("t4_chk",       64'(check_cnt), 64'd4);
        apb_xfer(20'h0, 32'h0, 1'b1);
        done_pulse(32'hA5, 2'b00, 1);
        idle(3);
        @(negedge clk);
        check("t4_chk_after", 64'(check_cnt), 64'd5);

        // 5: reset while in CAPT with two entries pending
        apb_xfer(20'h0, 32'h0, 1'b1);
        apb_xfer(20'h0, 32'h0, 1'b1);
        @(posedge clk); #1 operation_done = 1'b1; data_out = 32'h1;
        @(posedge clk); #1 rst = 1'b1; operation_done = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_level", 64'(fifo_level), 64'd0);
        check("t5_cnts",  64'({check_cnt, mismatch_cnt}), 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mismatch) pulses++;
        end
        check("t5_no_pulse", 64'(pulses), 64'd0);

        // 6: push on the same edge as a CAPT pop while full; push and pop cancel
        for (int i = 0; i < DEPTH; i++) apb_xfer(20'h0, 32'h0, 1'b1);
        @(posedge clk); #1;
        operation_done = 1'b1; data_out = '0; num_of_errors = 2'b00;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = '0; apb.PWDATA = '0;
        @(posedge clk); #1 operation_done = 1'b0; apb.PENABLE = 1'b1;
        @(posedge clk); #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(negedge clk);
        check("t6_overflow", 64'(overflow),   64'd0);
        check("t6_level",    64'(fifo_level), 64'(DEPTH));
        idle(3);
        @(negedge clk);
        check("t6_chk", 64'(check_cnt), 64'd1);

        // randomized traffic
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: apb_xfer(AAW'($urandom) & ~20'hC | (AAW'($urandom_range(0, 3)) << 2),
                                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom,
                                  1'b1);
                3: apb_xfer(AAW'($urandom), $urandom, 1'b0);
                4, 5, 6: begin
                    if (q.size() > 0 && $urandom_range(0, 2) != 0)
                        done_pulse(q[0].d, q[0].n, $urandom_range(1, 3));
                    else
                        done_pulse($urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 3));
                end
                7: begin
                    @(posedge clk); #1 sb_clear = 1'b1;
                    @(posedge clk); #1 sb_clear = 1'b0;
                end
                8: idle($urandom_range(1, 3));
                default: begin
                    if ($urandom_range(0, 15) == 0) begin
                        @(posedge clk); #1 rst = 1'b1;
                        @(posedge clk); #1 rst = 1'b0;
                    end else begin
                        idle(1);
                    end
                end
            endcase
        end
        idle(6);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
